// File: rtl/fir_sched.sv
// fir_sched: sequences ADC samples and host coefficient frames into a FIR datapath.
// Define FIR_SCHED_TIMEOUT_EN to build the fir_done watchdog.
module fir_sched #(
   parameter int TIMEOUT = 64,
   parameter int CFG_MAX = 17
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       s_valid,
   input  logic [7:0] s_data,
   output logic       s_ready,
   input  logic       c_valid,
   input  logic [7:0] c_data,
   input  logic       c_last,
   output logic       c_ready,
   output logic [7:0] fir_data_in,
   output logic       fir_enable,
   output logic       fir_configuration,
   output logic       fir_config_data_enable,
   input  logic       fir_done,
   input  logic [7:0] fir_data_out,
   input  logic [1:0] fir_overflow,
   output logic       m_valid,
   output logic [7:0] m_data,
   output logic [1:0] m_ovf,
   input  logic       m_ready,
   output logic       busy,
   output logic       timeout_err,
   output logic       cfg_err,
   input  logic       err_clr
);
   localparam logic [2:0] IDLE = 3'd0, ISSUE = 3'd1, WAIT = 3'd2, CFG_ENTER = 3'd3,
                          CFG_STREAM = 3'd4, CFG_EXIT = 3'd5, DRAIN = 3'd6;
   localparam int CW = $clog2(CFG_MAX + 1);

   logic [2:0]    state_q, state_d;
   logic [7:0]    din_q, din_d, mdata_q, mdata_d;
   logic [1:0]    movf_q, movf_d;
   logic          mvalid_q, mvalid_d, cde_q, cde_d, rdy_q, cfg_err_q, cfg_err_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tmo_hit;

   // rdy_q keeps s_ready low during reset and for the first cycle after it
   assign s_ready                = rdy_q && state_q == IDLE && !c_valid && (!mvalid_q || m_ready);
   assign c_ready                = state_q == CFG_STREAM || state_q == DRAIN;
   assign fir_enable             = state_q == ISSUE;
   assign fir_configuration      = state_q == CFG_ENTER || state_q == CFG_STREAM ||
                                   state_q == DRAIN || state_q == CFG_EXIT;
   assign fir_data_in            = din_q;
   assign fir_config_data_enable = cde_q;
   assign m_valid                = mvalid_q;
   assign m_data                 = mdata_q;
   assign m_ovf                  = movf_q;
   assign busy                   = state_q != IDLE;
   assign cfg_err                = cfg_err_q;

`ifdef FIR_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tmo_q;
   logic          tmo_err_q;
   assign tmo_hit     = state_q == WAIT && !fir_done && tmo_q == TW'(TIMEOUT - 1);
   assign timeout_err = tmo_err_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         tmo_q     <= '0;
         tmo_err_q <= 1'b0;
      end else begin
         tmo_q     <= (state_q == WAIT && !fir_done) ? tmo_q + 1'b1 : '0;
         tmo_err_q <= tmo_hit | (tmo_err_q & ~err_clr);
      end
`else
   assign tmo_hit     = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      din_d     = din_q;
      mdata_d   = mdata_q;
      movf_d    = movf_q;
      mvalid_d  = mvalid_q & ~m_ready;
      cde_d     = 1'b0;
      cnt_d     = cnt_q;
      cfg_err_d = cfg_err_q & ~err_clr;
      case (state_q)
         IDLE:
            if (c_valid && rdy_q) state_d = CFG_ENTER;
            else if (s_valid && s_ready) begin
               din_d   = s_data;
               state_d = ISSUE;
            end
         ISSUE: state_d = WAIT;
         WAIT:
            if (fir_done) begin
               mdata_d  = fir_data_out;
               movf_d   = fir_overflow;
               mvalid_d = 1'b1;
               state_d  = IDLE;
            end else if (tmo_hit) state_d = IDLE;
         CFG_ENTER: begin
            cnt_d   = '0;
            state_d = CFG_STREAM;
         end
         CFG_STREAM:
            if (c_valid) begin
               // a byte beyond CFG_MAX is swallowed and the rest of the frame drained
               if (cnt_q == CW'(CFG_MAX)) begin
                  cfg_err_d = 1'b1;
                  state_d   = c_last ? CFG_EXIT : DRAIN;
               end else begin
                  din_d   = c_data;
                  cde_d   = 1'b1;
                  cnt_d   = cnt_q + 1'b1;
                  state_d = c_last ? CFG_EXIT : CFG_STREAM;
               end
            end
         DRAIN: state_d = (c_valid && c_last) ? CFG_EXIT : DRAIN;
         CFG_EXIT: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q   <= IDLE;
         din_q     <= '0;
         mdata_q   <= '0;
         movf_q    <= '0;
         mvalid_q  <= 1'b0;
         cde_q     <= 1'b0;
         cnt_q     <= '0;
         cfg_err_q <= 1'b0;
         rdy_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         din_q     <= din_d;
         mdata_q   <= mdata_d;
         movf_q    <= movf_d;
         mvalid_q  <= mvalid_d;
         cde_q     <= cde_d;
         cnt_q     <= cnt_d;
         cfg_err_q <= cfg_err_d;
         rdy_q     <= 1'b1;
      end
endmodule

// File: tb/tb_fir_sched.sv
// tb_fir_sched: directed vector table plus hand sequences for fir_sched.
module tb_fir_sched;
   logic       clk = 1'b0, rst = 1'b1;
   logic       s_valid = 0, c_valid = 0, c_last = 0, m_ready = 0, err_clr = 0, fir_done = 0;
   logic [7:0] s_data = 0, c_data = 0, fir_data_out, fir_data_in, m_data;
   logic [1:0] fir_overflow, m_ovf;
   logic       s_ready, c_ready, fir_enable, fir_configuration, fir_config_data_enable;
   logic       m_valid, busy, timeout_err, cfg_err;

   fir_sched #(.TIMEOUT(64), .CFG_MAX(17)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .c_valid(c_valid), .c_data(c_data), .c_last(c_last), .c_ready(c_ready),
      .fir_data_in(fir_data_in), .fir_enable(fir_enable), .fir_configuration(fir_configuration),
      .fir_config_data_enable(fir_config_data_enable), .fir_done(fir_done),
      .fir_data_out(fir_data_out), .fir_overflow(fir_overflow), .m_valid(m_valid),
      .m_data(m_data), .m_ovf(m_ovf), .m_ready(m_ready), .busy(busy),
      .timeout_err(timeout_err), .cfg_err(cfg_err), .err_clr(err_clr));

   always #5 clk = ~clk;

   // FIR model: fir_done pulses dly cycles after fir_enable (dly>=2, 0 = never)
   int         dly = 0, cd = 0;
   logic [7:0] res = 0;
   logic [1:0] rovf = 0;
   assign fir_data_out = res;
   assign fir_overflow = rovf;
   always @(posedge clk) begin
      fir_done <= (cd == 2);
      cd <= fir_enable ? dly : (cd > 0 ? cd - 1 : 0);
   end

   int         n_cde = 0, n_cfg = 0, n_acc = 0;
   logic [7:0] cbytes [64];
   always @(posedge clk) begin
      if (fir_config_data_enable) begin
         cbytes[n_cde % 64] = fir_data_in;
         n_cde++;
      end
      if (fir_configuration) n_cfg++;
      if (c_valid && c_ready) n_acc++;
   end

   int total = 0, bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [7:0] sd;
      logic [7:0] res;
      logic [1:0] ovf;
      int         d;
   } vec_t;

   // handshakes one sample and waits for m_valid; lat counts cycles from handshake
   task automatic start_and_wait(input vec_t v, output int lat, output int ne, output logic [7:0] din);
      dly = v.d; res = v.res; rovf = v.ovf; s_data = v.sd; s_valid = 1;
      #1;
      for (int k = 0; k < 50 && !s_ready; k++) step();
      chk("s_ready_before_sample", s_ready, 1);
      step();
      s_valid = 0;
      lat = 1; ne = 0; din = 0;
      while (!m_valid && lat < 200) begin
         if (fir_enable) begin
            ne++;
            din = fir_data_in;
         end
         step();
         lat++;
      end
   endtask

   task automatic consume();
      m_ready = 1;
      step();
      m_ready = 0;
      #1;
      chk("m_valid_cleared", m_valid, 0);
   endtask

   vec_t       tv [4];
   logic [7:0] fr [5];
   int         lat, ne, b_cde, b_cfg, b_acc, viol;
   logic [7:0] din, held;

   initial begin
      tv[0] = '{8'h20, 8'h10, 2'b00, 3};
      tv[1] = '{8'hA5, 8'h7F, 2'b01, 2};
      tv[2] = '{8'h00, 8'hFF, 2'b10, 5};
      tv[3] = '{8'hFF, 8'h00, 2'b11, 4};
      fr = '{8'h03, 8'h40, 8'h20, 8'h10, 8'h08};

      step(); step();
      chk("rst_s_ready", s_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_fir_cfg", fir_configuration, 0);
      chk("rst_c_ready", c_ready, 0);
      chk("rst_timeout_err", timeout_err, 0);
      rst = 0;
      #1;
      chk("s_ready_first_cycle_after_rst", s_ready, 0);
      step();
      chk("s_ready_one_cycle_after_rst", s_ready, 1);

      foreach (tv[i]) begin
         start_and_wait(tv[i], lat, ne, din);
         chk($sformatf("v%0d_latency", i), lat, tv[i].d + 2);
         chk($sformatf("v%0d_enable_pulses", i), ne, 1);
         chk($sformatf("v%0d_fir_data_in", i), din, tv[i].sd);
         step(); step();
         chk($sformatf("v%0d_m_valid_hold", i), m_valid, 1);
         chk($sformatf("v%0d_m_data", i), m_data, tv[i].res);
         chk($sformatf("v%0d_m_ovf", i), m_ovf, tv[i].ovf);
         consume();
      end

      start_and_wait('{8'h31, 8'h42, 2'b01, 2}, lat, ne, din);
      held = m_data;
      dly = 3; res = 8'h99; rovf = 0; s_data = 8'h66; s_valid = 1;
      viol = 0;
      for (int k = 0; k < 10; k++) begin
         #1;
         if (s_ready || fir_enable || m_data !== held || !m_valid) viol++;
         step();
      end
      chk("bp_violations", viol, 0);
      chk("bp_m_data", m_data, 8'h42);
      m_ready = 1;
      #1;
      chk("bp_s_ready_on_handshake", s_ready, 1);
      step();
      m_ready = 0; s_valid = 0;
      #1;
      chk("bp_second_enable", fir_enable, 1);
      chk("bp_second_data", fir_data_in, 8'h66);
      for (int k = 0; k < 50 && !m_valid; k++) step();
      chk("bp_second_result", m_data, 8'h99);
      consume();

      b_cde = n_cde; b_cfg = n_cfg; b_acc = n_acc;
      dly = 2; res = 8'h77; rovf = 0; s_data = 8'h55; s_valid = 1;
      c_valid = 1; c_data = fr[0];
      #1;
      chk("cfg_priority_s_ready", s_ready, 0);
      for (int i = 0; i < 5; i++) begin
         c_data = fr[i]; c_last = (i == 4);
         #1;
         for (int k = 0; k < 20 && !c_ready; k++) step();
         step();
      end
      c_valid = 0; c_last = 0;
      for (int k = 0; k < 20 && !fir_enable; k++) step();
      chk("cfg_then_sample_enable", fir_enable, 1);
      chk("cfg_then_sample_data", fir_data_in, 8'h55);
      s_valid = 0;
      chk("cfg_pulses", n_cde - b_cde, 5);
      chk("cfg_config_cycles", n_cfg - b_cfg, 7);
      chk("cfg_accepted", n_acc - b_acc, 5);
      for (int i = 0; i < 5; i++) chk($sformatf("cfg_byte%0d", i), cbytes[(b_cde + i) % 64], fr[i]);
      for (int k = 0; k < 50 && !m_valid; k++) step();
      chk("cfg_sample_result", m_data, 8'h77);
      consume();

      b_cde = n_cde; b_acc = n_acc;
      c_valid = 1;
      for (int i = 0; i < 20; i++) begin
         c_data = 8'(i + 1); c_last = (i == 19);
         #1;
         for (int k = 0; k < 20 && !c_ready; k++) step();
         step();
      end
      c_valid = 0; c_last = 0;
      for (int k = 0; k < 20 && busy; k++) step();
      chk("ovl_forwarded", n_cde - b_cde, 17);
      chk("ovl_last_forwarded", cbytes[(b_cde + 16) % 64], 8'd17);
      chk("ovl_accepted", n_acc - b_acc, 20);
      chk("ovl_cfg_err", cfg_err, 1);
      chk("ovl_idle", busy, 0);
      err_clr = 1;
      step();
      err_clr = 0;
      #1;
      chk("ovl_err_clr", cfg_err, 0);

`ifdef FIR_SCHED_TIMEOUT_EN
      dly = 0; s_data = 8'h11; s_valid = 1;
      #1;
      for (int k = 0; k < 20 && !s_ready; k++) step();
      step();
      s_valid = 0;
      lat = 0;
      while (busy && lat < 300) begin
         step();
         lat++;
      end
      chk("wd_busy_cycles", lat, 65);
      chk("wd_timeout_err", timeout_err, 1);
      chk("wd_no_m_valid", m_valid, 0);
      chk("wd_s_ready", s_ready, 1);
      err_clr = 1;
      step();
      err_clr = 0;
      #1;
      chk("wd_err_clr", timeout_err, 0);
`else
      dly = 0; s_data = 8'h11; s_valid = 1;
      #1;
      for (int k = 0; k < 20 && !s_ready; k++) step();
      step();
      s_valid = 0;
      for (int k = 0; k < 150; k++) step();
      chk("nowd_still_busy", busy, 1);
      chk("nowd_timeout_err", timeout_err, 0);
      chk("nowd_no_m_valid", m_valid, 0);
      #2 rst = 1;
      #1;
      chk("nowd_rst_busy", busy, 0);
      step();
      rst = 0;
      step();
`endif

      c_valid = 1; c_data = 8'hA1;
      #1;
      for (int k = 0; k < 20 && !c_ready; k++) step();
      step();
      c_data = 8'hA2;
      step();
      #1;
      chk("mid_cfg_in_stream", c_ready, 1);
      chk("mid_cfg_pulse", fir_config_data_enable, 1);
      rst = 1;
      #1;
      chk("rst_mid_fir_cfg", fir_configuration, 0);
      chk("rst_mid_cde", fir_config_data_enable, 0);
      chk("rst_mid_data_in", fir_data_in, 0);
      chk("rst_mid_c_ready", c_ready, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_m_data", m_data, 0);
      c_valid = 0; s_valid = 1;
      step(); step();
      chk("rst_mid_s_ready_held", s_ready, 0);
      rst = 0;
      #1;
      chk("rst_rel_s_ready_0", s_ready, 0);
      step();
      chk("rst_rel_s_ready_1", s_ready, 1);
      s_valid = 0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/fir_sched.md
FIR_SCHED -- requirements
Module: fir_sched

Interface
REQ-001 The block SHALL use one clock and SHALL use an asynchronous, active-high reset.
REQ-002 Parameter TIMEOUT SHALL default to 64 and SHALL set the number of wait cycles for fir_done before the watchdog fires.
REQ-003 Parameter CFG_MAX SHALL default to 17 and SHALL set the maximum number of bytes in one coefficient frame (1 tap byte + 16 coefficients).
REQ-004 Port clk SHALL be an input, 1 bit: the system clock, rising edge.
REQ-005 Port rst SHALL be an input, 1 bit: the asynchronous, active-high reset.
REQ-006 Ports s_valid (in, 1), s_data (in, 8) and s_ready (out, 1) SHALL form the sample stream from the ADC.
REQ-007 Ports c_valid (in, 1), c_data (in, 8), c_last (in, 1) and c_ready (out, 1) SHALL form the coefficient-frame stream from the host.
REQ-008 Ports fir_data_in (out, 8), fir_enable (out, 1), fir_configuration (out, 1) and fir_config_data_enable (out, 1) SHALL drive the FIR datapath.
REQ-009 Ports fir_done (in, 1), fir_data_out (in, 8) and fir_overflow (in, 2) SHALL return results from the FIR datapath.
REQ-010 Ports m_valid (out, 1), m_data (out, 8), m_ovf (out, 2) and m_ready (in, 1) SHALL form the result stream.
REQ-011 Ports busy (out, 1), timeout_err (out, 1, sticky), cfg_err (out, 1, sticky) and err_clr (in, 1) SHALL provide status and error clearing.

Function
REQ-012 The FSM SHALL have the states IDLE, ISSUE, WAIT, CFG_ENTER, CFG_STREAM, CFG_EXIT and DRAIN.
REQ-013 s_ready SHALL be 1 only in IDLE, with c_valid=0, and with the result slot free (m_valid=0, or m_valid&&m_ready in the same cycle).
REQ-014 A sample handshake SHALL register s_data onto fir_data_in and SHALL move the FSM to ISSUE.
REQ-015 In ISSUE, the block SHALL assert fir_enable for exactly one cycle and then move to WAIT.
REQ-016 In WAIT, the block SHALL sample fir_data_out and fir_overflow on the edge where fir_done=1.
REQ-017 The sampled result SHALL load m_data and m_ovf, set m_valid on the next cycle, and return the FSM to IDLE.
REQ-018 The fixed latency from s_valid&&s_ready to m_valid SHALL be (FIR done latency)+2 cycles.
REQ-019 m_valid SHALL hold, and m_data and m_ovf SHALL stay stable, until m_ready=1; the slot is single-entry.
REQ-020 In IDLE with c_valid=1, configuration SHALL take priority over a pending sample, and SHALL never interrupt ISSUE or WAIT.
REQ-021 CFG_ENTER SHALL raise fir_configuration for one guard cycle.
REQ-022 In CFG_STREAM, c_ready SHALL be 1, and each accepted byte SHALL appear on fir_data_in with fir_config_data_enable=1 for one cycle on the following cycle.
REQ-023 The first byte of a frame SHALL be the tap number (0..15); the following bytes SHALL be the coefficients h_0 upward.
REQ-024 Acceptance of c_last SHALL move the FSM to CFG_EXIT.
REQ-025 CFG_EXIT SHALL hold fir_configuration for one cycle, deassert it, and then return to IDLE.
REQ-026 If a frame has more than CFG_MAX bytes before c_last, the block SHALL set cfg_err and enter DRAIN.
REQ-027 DRAIN SHALL accept and discard bytes with c_ready=1 and no fir_config_data_enable until c_last, then SHALL go to CFG_EXIT.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 err_clr SHALL clear both sticky error flags; if a new error is raised in the same cycle, setting SHALL win.

Reset
REQ-030 While rst=1, all outputs and internal state SHALL be 0 and the FSM SHALL be in IDLE, including when reset is applied mid-frame or mid-sample.
REQ-031 After reset is released, the first s_ready SHALL be possible one cycle after deassertion.

Configuration
REQ-032 Macro FIR_SCHED_TIMEOUT_EN SHALL select whether the watchdog is compiled in.
REQ-033 With FIR_SCHED_TIMEOUT_EN defined, the block SHALL count the cycles spent in WAIT.
REQ-034 With FIR_SCHED_TIMEOUT_EN defined, reaching TIMEOUT without fir_done SHALL set timeout_err and return the FSM to IDLE with no result; m_valid SHALL not be set.
REQ-035 With FIR_SCHED_TIMEOUT_EN not defined, WAIT SHALL wait indefinitely, timeout_err SHALL be tied to 0, and no counter SHALL be built.

Verification
REQ-036 Single sample: s_data=0x20 with fir_done 3 cycles after fir_enable, and fir_data_out=0x10 -> one fir_enable pulse, m_valid with m_data=0x10, m_ovf=00.
REQ-037 Backpressure: m_ready=0 for 10 cycles with a second s_valid pending -> s_ready=0 throughout, m_data stable, and the second sample issued only after the handshake.
REQ-038 Config priority: c_valid and s_valid asserted together in IDLE with frame {0x03,0x40,0x20,0x10,0x08(last)} -> 5 fir_config_data_enable pulses carrying those bytes, fir_configuration high 7 cycles, and the sample issued afterward.
REQ-039 Overlength frame: 20 bytes with c_last on the 20th -> 17 bytes forwarded, cfg_err=1, all 20 accepted, and err_clr clears cfg_err.
REQ-040 Watchdog (macro on, TIMEOUT=64): fir_done never asserted -> timeout_err=1 after 64 WAIT cycles, no m_valid, and s_ready returns.
REQ-041 Reset mid-CFG_STREAM: rst pulsed after 2 bytes -> fir_configuration=0 immediately, all outputs 0, and FSM in IDLE.
